control_pasabajas: RTL and testbench

//  Sequencer for the 20 kHz low-pass IIR datapath (coef mux, f/f1/f2 memory, MAC accumulator, output reg).
//  Per sample: 3 MAC steps build the new state f, f is stored, accumulator cleared, 3 MAC steps build y,
//  y is latched, memory shifted. Sample trigger is an external strobe or an internal divider.

---
 rtl/control_pasabajas.sv | 113 +++++++++++
 tb/tb_control_pasabajas.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/control_pasabajas.sv
// Sequencer for the 20 kHz low-pass IIR datapath: steps the coefficient mux, memory
// write/shift, accumulator clear and output latch once per sample trigger.
module control_pasabajas #(
  parameter int unsigned DIV_MUESTRA = 2500,
  parameter int unsigned ANCHO_DIV   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       habilitar,
  input  logic       usar_int,
  input  logic       muestra_lista,
  output logic [3:0] sel,
  output logic       leer,
  output logic       desp,
  output logic       leer_y,
  output logic       rst_acum,
  output logic       ocupado,
  output logic       listo,
  output logic       err_overrun
);

  localparam logic [ANCHO_DIV-1:0] DIV_FIN = ANCHO_DIV'(DIV_MUESTRA - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_WF, S_CLR, S_Y0, S_Y1, S_Y2, S_WY, S_SH
  } estado_t;

  estado_t              estado, estado_sig;
  logic [ANCHO_DIV-1:0] div_cnt;
  logic                 div_tick;
  logic                 disparo;

  assign div_tick = (div_cnt == DIV_FIN);
  assign disparo  = habilitar & (usar_int ? div_tick : muestra_lista);

  // Free-running sample divider, independent of state and habilitar
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt <= '0;
    else if (div_tick) div_cnt <= '0;
    else div_cnt <= div_cnt + ANCHO_DIV'(1);
  end

  // Next-state: one step per cycle, only IDLE waits for a trigger
  always_comb begin
    estado_sig = estado;
    case (estado)
      S_IDLE:  estado_sig = disparo ? S_F0 : S_IDLE;
      S_F0:    estado_sig = S_F1;
      S_F1:    estado_sig = S_F2;
      S_F2:    estado_sig = S_WF;
      S_WF:    estado_sig = S_CLR;
      S_CLR:   estado_sig = S_Y0;
      S_Y0:    estado_sig = S_Y1;
      S_Y1:    estado_sig = S_Y2;
      S_Y2:    estado_sig = S_WY;
      S_WY:    estado_sig = S_SH;
      S_SH:    estado_sig = S_IDLE;
      default: estado_sig = S_IDLE;
    endcase
  end

  // State plus outputs decoded from the next state, so outputs track state with no lag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado      <= S_IDLE;
      sel         <= 4'd0;
      leer        <= 1'b0;
      desp        <= 1'b0;
      leer_y      <= 1'b0;
      rst_acum    <= 1'b1;
      ocupado     <= 1'b0;
      listo       <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      estado      <= estado_sig;
      sel         <= 4'd0;
      leer        <= 1'b0;
      desp        <= 1'b0;
      leer_y      <= 1'b0;
      rst_acum    <= 1'b0;
      listo       <= 1'b0;
      ocupado     <= (estado_sig != S_IDLE);
      err_overrun <= err_overrun | (disparo & ocupado);
      case (estado_sig)
        S_IDLE: rst_acum <= 1'b1;
        S_F0:   sel <= 4'd0;
        S_F1:   sel <= 4'd1;
        S_F2:   sel <= 4'd2;
        S_WF: begin
          sel  <= 4'd2;
          leer <= 1'b1;
        end
        S_CLR: begin
          sel      <= 4'd3;
          rst_acum <= 1'b1;
        end
        S_Y0:   sel <= 4'd3;
        S_Y1:   sel <= 4'd4;
        S_Y2:   sel <= 4'd5;
        S_WY: begin
          sel    <= 4'd5;
          leer_y <= 1'b1;
        end
        S_SH: begin
          desp  <= 1'b1;
          listo <= 1'b1;
        end
        default: rst_acum <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_control_pasabajas.sv
// Self-checking bench for control_pasabajas: cycle-by-cycle comparison against a
// sample-position model, directed scenarios with literal expectations, then random traffic.
module tb_control_pasabajas;

  localparam int unsigned DIV = 20;

  logic       clk = 1'b0;
  logic       rst, habilitar, usar_int, muestra_lista;
  logic [3:0] sel;
  logic       leer, desp, leer_y, rst_acum, ocupado, listo, err_overrun;

  control_pasabajas #(.DIV_MUESTRA(DIV), .ANCHO_DIV(16)) dut (
    .clk(clk), .rst(rst), .habilitar(habilitar), .usar_int(usar_int),
    .muestra_lista(muestra_lista), .sel(sel), .leer(leer), .desp(desp),
    .leer_y(leer_y), .rst_acum(rst_acum), .ocupado(ocupado), .listo(listo),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: position inside the sample (0 = idle, 1..10 = cycles after the trigger)
  int m_pos;
  int m_div;
  bit m_err;
  int sel_tab [0:10] = '{0, 0, 1, 2, 2, 3, 3, 4, 5, 5, 0};

  task automatic model_reset();
    m_pos = 0;
    m_div = 0;
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    bit t;
    t = habilitar && (usar_int ? (m_div == int'(DIV) - 1) : muestra_lista);
    if (t && m_pos != 0) m_err = 1'b1;
    if (m_pos == 0) m_pos = t ? 1 : 0;
    else m_pos = (m_pos == 10) ? 0 : m_pos + 1;
    m_div = (m_div == int'(DIV) - 1) ? 0 : m_div + 1;
  endtask

  task automatic check_all(input string tag);
    logic [10:0] req, act;
    req = {4'(sel_tab[m_pos]), m_pos == 4, m_pos == 10, m_pos == 9,
           (m_pos == 0 || m_pos == 5), m_pos != 0, m_pos == 10, m_err};
    act = {sel, leer, desp, leer_y, rst_acum, ocupado, listo, err_overrun};
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s t=%0t pos=%0d actual{sel,leer,desp,leer_y,rst_acum,ocup,listo,err}=%b required=%b",
               tag, $time, m_pos, act, req);
    end
  endtask

  task automatic lit(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One clock: advance the model on the edge, compare 1 time unit later
  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    check_all("ciclo");
  endtask

  task automatic strobe_and_count(input int ncyc, output int n_listo, output int n_leer_y);
    n_listo  = 0;
    n_leer_y = 0;
    muestra_lista = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      cyc();
      if (k == 1) muestra_lista = 1'b0;
      if (listo) n_listo++;
      if (leer_y) n_leer_y++;
    end
  endtask

  initial begin
    int sel_seq [0:9];
    int req_seq [0:9];
    int p_leer, p_rst, p_leer_y, p_listo, n_l, n_ly, n_le, n_de;
    req_seq = '{0, 1, 2, 2, 3, 3, 4, 5, 5, 0};

    // 1: reset while traffic is present
    rst = 1'b1; habilitar = 1'b1; usar_int = 1'b0; muestra_lista = 1'b1;
    model_reset();
    repeat (3) cyc();
    lit("reset_sel", int'(sel), 0);
    lit("reset_rst_acum", int'(rst_acum), 1);
    lit("reset_others", int'({leer, leer_y, desp, listo, ocupado, err_overrun}), 0);
    rst = 1'b0; muestra_lista = 1'b0;
    repeat (3) cyc();

    // 2: single external strobe, pin the sequence positions
    p_leer = 0; p_rst = 0; p_leer_y = 0; p_listo = 0;
    muestra_lista = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k == 1) muestra_lista = 1'b0;
      sel_seq[k-1] = int'(sel);
      if (leer) p_leer = k;
      if (rst_acum) p_rst = k;
      if (leer_y) p_leer_y = k;
      if (listo && desp) p_listo = k;
    end
    for (int k = 0; k < 10; k++) lit($sformatf("seq_sel[%0d]", k + 1), sel_seq[k], req_seq[k]);
    lit("pos_leer", p_leer, 4);
    lit("pos_rst_acum", p_rst, 5);
    lit("pos_leer_y", p_leer_y, 9);
    lit("pos_listo", p_listo, 10);
    repeat (3) cyc();

    // 4: second strobe 5 cycles later is an overrun and is dropped
    n_l = 0;
    muestra_lista = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      muestra_lista = (k == 5);
      if (listo) n_l++;
    end
    lit("overrun_listo_count", n_l, 1);
    lit("overrun_flag", int'(err_overrun), 1);
    repeat (20) cyc();
    lit("overrun_sticky", int'(err_overrun), 1);

    // 5: asynchronous reset in Y1, then a clean sample
    muestra_lista = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      muestra_lista = 1'b0;
    end
    lit("at_y1_sel", int'(sel), 4);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("reset_async");
    lit("async_rst_acum", int'(rst_acum), 1);
    cyc();
    rst = 1'b0;
    repeat (2) cyc();
    lit("err_cleared", int'(err_overrun), 0);
    strobe_and_count(11, n_l, n_ly);
    lit("after_rst_listo", n_l, 1);
    lit("after_rst_leer_y", n_ly, 1);

    // 6: habilitar dropped in F1
    muestra_lista = 1'b1;
    n_l = 0;
    for (int k = 1; k <= 11; k++) begin
      cyc();
      muestra_lista = 1'b0;
      if (k == 2) habilitar = 1'b0;
      if (listo) n_l++;
    end
    lit("disable_completes", n_l, 1);
    n_l = 0;
    for (int s = 0; s < 3; s++) begin
      strobe_and_count(12, n_le, n_ly);
      n_l += n_le;
    end
    lit("disabled_ignored", n_l, 0);
    lit("disabled_no_overrun", int'(err_overrun), 0);
    habilitar = 1'b1;
    strobe_and_count(11, n_l, n_ly);
    lit("reenabled_listo", n_l, 1);

    // 3: internal divider, one sample per DIV cycles
    usar_int = 1'b1;
    repeat (int'(DIV)) cyc();
    n_l = 0; n_le = 0; n_ly = 0; n_de = 0;
    for (int k = 0; k < 100 * int'(DIV); k++) begin
      cyc();
      if (listo) n_l++;
      if (leer) n_le++;
      if (leer_y) n_ly++;
      if (desp) n_de++;
      if (int'(leer) + int'(leer_y) + int'(desp) > 1) lit("one_strobe_per_cycle", 2, 1);
    end
    lit("int_listo", n_l, 100);
    lit("int_leer", n_le, 100);
    lit("int_leer_y", n_ly, 100);
    lit("int_desp", n_de, 100);
    lit("int_no_overrun", int'(err_overrun), 0);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      habilitar     = ($urandom_range(0, 9) != 0);
      muestra_lista = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 99) == 0) usar_int = ~usar_int;
      rst = ($urandom_range(0, 399) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
